multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl -- control FSM for a five-instruction-class multi-cycle MIPS
// datapath (R-type add/sub/and/or/slt, addi, lw, sw, beq).
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   opCode, funct         instruction fields, valid from DECODE onward
//   memReady              memory completes the current access this cycle
//   PCWrite..ALUOp        datapath control strobes/selects, decoded from state
//   state                 current state code
//   instrCount            retired-instruction counter (wraps)
//   illegalOp             one-cycle pulse when DECODE rejects the instruction
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opCode,
    input  logic [5:0]  funct,
    input  logic        memReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCSource,
    output logic        IorD,
    output logic        MemReadEn,
    output logic        MemWriteEn,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWriteEn,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [3:0]  state,
    output logic [31:0] instrCount,
    output logic        illegalOp
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_ADDIEX = 4'd8;
    localparam logic [3:0] S_ADDIWB = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [3:0]  state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        rtype_ok;
    logic [2:0]  funct_alu_op;
    logic        retire;

    // funct -> ALU operation; rtype_ok flags the supported subset
    always_comb begin
        rtype_ok     = 1'b1;
        funct_alu_op = 3'b000;
        case (funct)
            6'h20:   funct_alu_op = 3'b000;
            6'h22:   funct_alu_op = 3'b001;
            6'h24:   funct_alu_op = 3'b010;
            6'h25:   funct_alu_op = 3'b011;
            6'h2A:   funct_alu_op = 3'b100;
            default: rtype_ok     = 1'b0;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next state and retirement
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opCode == OP_LW || opCode == OP_SW)     state_d = S_MEMADR;
                else if (opCode == OP_RTYPE && rtype_ok)    state_d = S_EXEC;
                else if (opCode == OP_ADDI)                 state_d = S_ADDIEX;
                else if (opCode == OP_BEQ)                  state_d = S_BRANCH;
                else                                        state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (opCode == OP_LW)      state_d = S_MEMRD;
                else if (opCode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = memReady ? S_FETCH : S_MEMWR;
                retire  = memReady;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
    end

    // Control outputs; everything is forced low while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemReadEn   = 1'b0;
        MemWriteEn  = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWriteEn  = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        illegalOp   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemReadEn = 1'b1;
                    ALUSrcB   = 2'b01;
                    IRWrite   = memReady;
                    PCWrite   = memReady;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    // DECODE falls back to FETCH exactly when the instruction is unsupported
                    illegalOp = (state_d == S_FETCH);
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    IorD      = 1'b1;
                    MemReadEn = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    MemWriteEn = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWriteEn = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = funct_alu_op;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWriteEn = 1'b1;
                    ALUOp      = funct_alu_op;
                end
                S_ADDIWB: RegWriteEn = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 3'b001;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign instrCount = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl. Inputs change just after each falling
// edge and outputs are sampled 1 ns later, so each step observes one state.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opCode, funct;
    logic        memReady;
    logic        PCWrite, PCWriteCond, PCSource, IorD, MemReadEn, MemWriteEn;
    logic        IRWrite, RegDst, MemtoReg, RegWriteEn, ALUSrcA, illegalOp;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] instrCount;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .memReady(memReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWriteEn(RegWriteEn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .instrCount(instrCount), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    // Packed view: PCW PCWC PCS IorD MRd MWr IRW RDst M2R RegW SrcA SrcB[2] Op[3] ill
    logic [16:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, PCSource, IorD, MemReadEn, MemWriteEn, IRWrite,
                   RegDst, MemtoReg, RegWriteEn, ALUSrcA, ALUSrcB, ALUOp, illegalOp};

    localparam logic [16:0] C_ZERO     = 17'b0_0_0_0_0_0_0_0_0_0_0_00_000_0;
    localparam logic [16:0] C_FETCH    = 17'b1_0_0_0_1_0_1_0_0_0_0_01_000_0;
    localparam logic [16:0] C_FETCH_ST = 17'b0_0_0_0_1_0_0_0_0_0_0_01_000_0;
    localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_0_0_0_0_11_000_0;
    localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_000_1;
    localparam logic [16:0] C_MEMADR   = 17'b0_0_0_0_0_0_0_0_0_0_1_10_000_0;
    localparam logic [16:0] C_MEMRD    = 17'b0_0_0_1_1_0_0_0_0_0_0_00_000_0;
    localparam logic [16:0] C_MEMWB    = 17'b0_0_0_0_0_0_0_0_1_1_0_00_000_0;
    localparam logic [16:0] C_MEMWR    = 17'b0_0_0_1_0_1_0_0_0_0_0_00_000_0;
    localparam logic [16:0] C_EXEC_SUB = 17'b0_0_0_0_0_0_0_0_0_0_1_00_001_0;
    localparam logic [16:0] C_ALUWB_SB = 17'b0_0_0_0_0_0_0_1_0_1_0_00_001_0;
    localparam logic [16:0] C_ADDIWB   = 17'b0_0_0_0_0_0_0_0_0_1_0_00_000_0;
    localparam logic [16:0] C_BRANCH   = 17'b0_1_1_0_0_0_0_0_0_0_1_00_001_0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c,
                        input logic [31:0] cnt);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".ctrl"}, {15'd0, ctrl}, {15'd0, c});
        chk({tag, ".cnt"}, instrCount, cnt);
    endtask

    // Advance to the next sampling point
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opCode = 6'h00; funct = 6'h00; memReady = 1'b1;
        @(posedge clk); @(posedge clk);
        nxt();
        step("reset", 4'd0, C_ZERO, 32'd0);

        // lw, memory always ready
        @(negedge clk); rst = 1'b0; opCode = 6'h23; #1;
        step("lw.fetch", 4'd0, C_FETCH, 32'd0);
        nxt(); step("lw.decode", 4'd1, C_DECODE, 32'd0);
        nxt(); step("lw.memadr", 4'd2, C_MEMADR, 32'd0);
        nxt(); step("lw.memrd", 4'd3, C_MEMRD, 32'd0);
        nxt(); step("lw.memwb", 4'd4, C_MEMWB, 32'd0);
        nxt(); step("lw.done", 4'd0, C_FETCH, 32'd1);

        // R-type sub, after a one-cycle fetch stall
        memReady = 1'b0; opCode = 6'h00; funct = 6'h22; #1;
        step("sub.fetch_stall", 4'd0, C_FETCH_ST, 32'd1);
        nxt(); step("sub.fetch_hold", 4'd0, C_FETCH_ST, 32'd1);
        memReady = 1'b1; #1;
        step("sub.fetch", 4'd0, C_FETCH, 32'd1);
        nxt(); step("sub.decode", 4'd1, C_DECODE, 32'd1);
        nxt(); step("sub.exec", 4'd6, C_EXEC_SUB, 32'd1);
        nxt(); step("sub.aluwb", 4'd7, C_ALUWB_SB, 32'd1);
        nxt(); step("sub.done", 4'd0, C_FETCH, 32'd2);

        // sw with three stalled MEMWR cycles
        opCode = 6'h2B;
        nxt(); step("sw.decode", 4'd1, C_DECODE, 32'd2);
        nxt(); step("sw.memadr", 4'd2, C_MEMADR, 32'd2);
        @(negedge clk); memReady = 1'b0; #1;
        step("sw.memwr0", 4'd5, C_MEMWR, 32'd2);
        nxt(); step("sw.memwr1", 4'd5, C_MEMWR, 32'd2);
        nxt(); step("sw.memwr2", 4'd5, C_MEMWR, 32'd2);
        @(negedge clk); memReady = 1'b1; #1;
        step("sw.memwr3", 4'd5, C_MEMWR, 32'd2);
        nxt(); step("sw.done", 4'd0, C_FETCH, 32'd3);

        // Unsupported opcode
        opCode = 6'h3F;
        nxt(); step("ill.decode", 4'd1, C_DEC_ILL, 32'd3);
        nxt(); step("ill.done", 4'd0, C_FETCH, 32'd3);

        // R-type with unsupported funct
        opCode = 6'h00; funct = 6'h21;
        nxt(); step("illf.decode", 4'd1, C_DEC_ILL, 32'd3);
        nxt(); step("illf.done", 4'd0, C_FETCH, 32'd3);

        // addi
        opCode = 6'h08;
        nxt(); step("addi.decode", 4'd1, C_DECODE, 32'd3);
        nxt(); step("addi.ex", 4'd8, C_MEMADR, 32'd3);
        nxt(); step("addi.wb", 4'd9, C_ADDIWB, 32'd3);
        nxt(); step("addi.done", 4'd0, C_FETCH, 32'd4);

        // Reset in the middle of a MEMRD stall
        opCode = 6'h23;
        nxt(); step("rst.decode", 4'd1, C_DECODE, 32'd4);
        nxt(); step("rst.memadr", 4'd2, C_MEMADR, 32'd4);
        @(negedge clk); memReady = 1'b0; #1;
        step("rst.memrd", 4'd3, C_MEMRD, 32'd4);
        @(negedge clk); rst = 1'b1; #1;
        step("rst.held", 4'd3, C_ZERO, 32'd4);
        @(negedge clk); memReady = 1'b1; #1;
        step("rst.applied", 4'd0, C_ZERO, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        step("rst.release", 4'd0, C_FETCH, 32'd0);

        // Counter wrap on beq retirement, starting from an all-ones count
        dut.instr_count_q = 32'hFFFF_FFFF;
        opCode = 6'h04;
        nxt(); step("beq.decode", 4'd1, C_DECODE, 32'hFFFF_FFFF);
        nxt(); step("beq.branch", 4'd10, C_BRANCH, 32'hFFFF_FFFF);
        nxt(); step("beq.wrap", 4'd0, C_FETCH, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
